// File: rtl/t9990_vram_responder_if.sv
// VDP-facing RAM bus of the tiny9990: slot strobe, request lines and the read/ack return path.
// The master is the VDP and the slave is the memory responder.
interface t9990_vram_responder_if;
  logic        ram_req;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        ram_rfsh_n;
  logic [18:0] ram_addr;
  logic [31:0] ram_din;
  logic [1:0]  ram_din_size;
  logic [31:0] ram_dout;
  logic        ram_ack_n;

  modport master (
    input  ram_req, ram_dout, ram_ack_n,
    output ram_oe_n, ram_we_n, ram_rfsh_n, ram_addr, ram_din, ram_din_size
  );

  modport slave (
    output ram_req, ram_dout, ram_ack_n,
    input  ram_oe_n, ram_we_n, ram_rfsh_n, ram_addr, ram_din, ram_din_size
  );
endinterface

// File: rtl/t9990_vram_responder.sv
// Memory-side responder: offers RAM slots to the VDP and maps its 8/32-bit byte-space
// accesses onto a 16-bit asynchronous SRAM, one or two word phases per access.
module t9990_vram_responder #(
  parameter int SLOT_PERIOD = 16,
  parameter int SRAM_WAIT   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  t9990_vram_responder_if.slave io_ram,
  output logic [17:0]           o_sram_a,
  output logic [15:0]           o_sram_dq_out,
  input  logic [15:0]           i_sram_dq_in,
  output logic                  o_sram_dq_oe,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n,
  output logic                  o_sram_ub_n,
  output logic                  o_sram_lb_n,
  output logic                  o_err
);
  localparam int SLOT_W = (SLOT_PERIOD > 1) ? $clog2(SLOT_PERIOD) : 1;
  localparam int WAIT_W = $clog2(SRAM_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_PH0, S_REC0, S_PH1, S_REC1, S_ACK
  } state_t;

  state_t              r_state, w_state_next;
  logic [SLOT_W-1:0]   r_slot;
  logic [WAIT_W-1:0]   r_wait, w_wait_next;
  logic                r_wr, r_rd, r_sz32, r_a0;
  logic [15:0]         r_din_hi;
  logic [15:0]         r_rd_lo, r_rd_hi, w_rd_lo_next, w_rd_hi_next;
  logic [17:0]         r_sram_a, w_sram_a_next;
  logic [15:0]         r_dq_out, w_dq_out_next;
  logic                r_dq_oe, w_dq_oe_next;
  logic [31:0]         r_dout, w_dout_next;
  logic                r_ack_n, w_ack_n_next;
  logic                r_err, w_err_next;
  logic                r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
  logic                w_req, w_sample, w_live_wr, w_live_rd, w_err_req;
  logic                w_wr, w_rd, w_sz32, w_a0, w_ph_next;
  logic [7:0]          w_byte;

  // Reset gates the slot strobe so no request is offered while held in reset.
  assign w_req     = !i_reset && (r_slot == '0) && (r_state == S_IDLE);
  assign w_sample  = (r_state == S_SAMPLE);
  assign w_live_wr = !io_ram.ram_we_n;
  assign w_live_rd = !io_ram.ram_oe_n && io_ram.ram_we_n;
  assign w_err_req = (!io_ram.ram_we_n && !io_ram.ram_oe_n)
                   || (!io_ram.ram_rfsh_n && (!io_ram.ram_we_n || !io_ram.ram_oe_n))
                   || ((!io_ram.ram_we_n || !io_ram.ram_oe_n) && io_ram.ram_din_size[0]);

  // During SAMPLE the request is still on the bus; afterwards the captured copy is used.
  assign w_wr   = w_sample ? w_live_wr : r_wr;
  assign w_rd   = w_sample ? w_live_rd : r_rd;
  assign w_sz32 = w_sample ? (io_ram.ram_din_size != 2'd0) : r_sz32;
  assign w_a0   = w_sample ? io_ram.ram_addr[0] : r_a0;
  assign w_byte = r_a0 ? r_rd_lo[15:8] : r_rd_lo[7:0];

  always_comb begin
    w_state_next  = r_state;
    w_wait_next   = r_wait;
    w_sram_a_next = r_sram_a;
    w_dq_out_next = r_dq_out;
    w_dq_oe_next  = r_dq_oe;
    w_rd_lo_next  = r_rd_lo;
    w_rd_hi_next  = r_rd_hi;
    w_dout_next   = r_dout;
    w_ack_n_next  = 1'b1;
    w_err_next    = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (w_err_req) w_err_next = 1'b1;
        if (w_live_wr || w_live_rd) begin
          w_state_next  = S_PH0;
          w_wait_next   = '0;
          w_sram_a_next = w_sz32 ? {io_ram.ram_addr[18:2], 1'b0} : io_ram.ram_addr[18:1];
          w_dq_out_next = w_sz32 ? io_ram.ram_din[15:0]
                                 : {io_ram.ram_din[7:0], io_ram.ram_din[7:0]};
          w_dq_oe_next  = w_live_wr;
        end else if (!io_ram.ram_rfsh_n) begin
          w_state_next = S_ACK;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_PH0, S_PH1: begin
        if (r_wait == WAIT_W'(SRAM_WAIT - 1)) begin
          w_state_next = (r_state == S_PH0) ? S_REC0 : S_REC1;
          if (r_rd && r_state == S_PH0) w_rd_lo_next = i_sram_dq_in;
          if (r_rd && r_state == S_PH1) w_rd_hi_next = i_sram_dq_in;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_REC0: begin
        if (r_sz32) begin
          w_state_next  = S_PH1;
          w_wait_next   = '0;
          w_sram_a_next = {r_sram_a[17:1], 1'b1};
          w_dq_out_next = r_din_hi;
        end else begin
          w_state_next = S_ACK;
        end
      end
      S_REC1:  w_state_next = S_ACK;
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_state_next == S_ACK) begin
      w_ack_n_next = 1'b0;
      w_dq_oe_next = 1'b0;
      if (!w_sample && r_rd) w_dout_next = r_sz32 ? {r_rd_hi, r_rd_lo} : {4{w_byte}};
    end
  end

  // Strobes are registered from the next state so the SRAM pins stay glitch-free.
  assign w_ph_next = (w_state_next == S_PH0) || (w_state_next == S_PH1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_slot   <= '0;
      r_wait   <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_sz32   <= 1'b0;
      r_a0     <= 1'b0;
      r_din_hi <= '0;
      r_rd_lo  <= '0;
      r_rd_hi  <= '0;
      r_sram_a <= '0;
      r_dq_out <= '0;
      r_dq_oe  <= 1'b0;
      r_dout   <= '0;
      r_ack_n  <= 1'b1;
      r_err    <= 1'b0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_lb_n   <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_slot   <= (r_slot == SLOT_W'(SLOT_PERIOD - 1)) ? '0 : r_slot + 1'b1;
      r_wait   <= w_wait_next;
      if (w_sample) begin
        r_wr     <= w_live_wr;
        r_rd     <= w_live_rd;
        r_sz32   <= (io_ram.ram_din_size != 2'd0);
        r_a0     <= io_ram.ram_addr[0];
        r_din_hi <= io_ram.ram_din[31:16];
      end
      r_rd_lo  <= w_rd_lo_next;
      r_rd_hi  <= w_rd_hi_next;
      r_sram_a <= w_sram_a_next;
      r_dq_out <= w_dq_out_next;
      r_dq_oe  <= w_dq_oe_next;
      r_dout   <= w_dout_next;
      r_ack_n  <= w_ack_n_next;
      r_err    <= w_err_next;
      r_ce_n   <= !w_ph_next;
      r_oe_n   <= !(w_ph_next && w_rd);
      r_we_n   <= !(w_ph_next && w_wr);
      r_ub_n   <= !(w_ph_next && (w_sz32 || w_a0));
      r_lb_n   <= !(w_ph_next && (w_sz32 || !w_a0));
    end
  end

  assign io_ram.ram_req   = w_req;
  assign io_ram.ram_dout  = r_dout;
  assign io_ram.ram_ack_n = r_ack_n;
  assign o_sram_a         = r_sram_a;
  assign o_sram_dq_out    = r_dq_out;
  assign o_sram_dq_oe     = r_dq_oe;
  assign o_sram_ce_n      = r_ce_n;
  assign o_sram_oe_n      = r_oe_n;
  assign o_sram_we_n      = r_we_n;
  assign o_sram_ub_n      = r_ub_n;
  assign o_sram_lb_n      = r_lb_n;
  assign o_err            = r_err;
endmodule

// File: tb/tb_t9990_vram_responder.sv
// Directed bench for t9990_vram_responder: a behavioural SRAM plus a VDP driver that records
// each transaction cycle by cycle, then hand-computed expectations checked with assertions.
module tb_t9990_vram_responder;
  logic        clk = 1'b0;
  logic        i_reset;
  logic [17:0] sram_a;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic        err;

  int checks = 0;
  int errors = 0;

  t9990_vram_responder_if ram();

  t9990_vram_responder #(.SLOT_PERIOD(16), .SRAM_WAIT(2)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .io_ram        (ram),
    .o_sram_a      (sram_a),
    .o_sram_dq_out (sram_dq_out),
    .i_sram_dq_in  (sram_dq_in),
    .o_sram_dq_oe  (sram_dq_oe),
    .o_sram_ce_n   (sram_ce_n),
    .o_sram_oe_n   (sram_oe_n),
    .o_sram_we_n   (sram_we_n),
    .o_sram_ub_n   (sram_ub_n),
    .o_sram_lb_n   (sram_lb_n),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  // Behavioural async SRAM; contents are preloaded while reset is held.
  logic [15:0] mem [0:262143];
  assign sram_dq_in = mem[sram_a];
  always @(posedge clk) begin
    if (i_reset) begin
      mem[18'h00082] <= 16'hBEEF;
      mem[18'h00083] <= 16'hDEAD;
      mem[18'h3FFFF] <= 16'h1111;
      mem[18'h00008] <= 16'h1234;
      mem[18'h00100] <= 16'h0000;
      mem[18'h00101] <= 16'h0000;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_dq_out[15:8];
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_dq_out[7:0];
    end
  end

  localparam int MAXK = 40;
  logic [4:0]  tr_str  [0:MAXK];  // {ce_n, oe_n, we_n, ub_n, lb_n}
  logic [17:0] tr_a    [0:MAXK];
  logic [15:0] tr_dq   [0:MAXK];
  logic [31:0] tr_dout [0:MAXK];
  logic        tr_dqoe [0:MAXK];
  int n_ack, first_ack, first_req, n_oe_lo, n_we_lo, n_ce_lo, n_dqoe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    ram.ram_oe_n     = 1'b1;
    ram.ram_we_n     = 1'b1;
    ram.ram_rfsh_n   = 1'b1;
    ram.ram_addr     = '0;
    ram.ram_din      = '0;
    ram.ram_din_size = 2'd0;
  endtask

  // Waits for a slot, presents one request, records cycles t+1..t+ncyc; rst_at>0 pulses reset.
  task automatic run_req(input string name, input logic oe_n, input logic we_n,
                         input logic rfsh_n, input logic [18:0] addr, input logic [31:0] din,
                         input logic [1:0] size, input int ncyc, input int rst_at);
    int guard = 0;
    @(negedge clk);
    while (!ram.ram_req && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_slot"}, {31'd0, ram.ram_req}, 32'd1);
    ram.ram_oe_n = oe_n; ram.ram_we_n = we_n; ram.ram_rfsh_n = rfsh_n;
    ram.ram_addr = addr; ram.ram_din = din; ram.ram_din_size = size;
    n_ack = 0; first_ack = 0; first_req = 0;
    n_oe_lo = 0; n_we_lo = 0; n_ce_lo = 0; n_dqoe = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      tr_str[k]  = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
      tr_a[k]    = sram_a;
      tr_dq[k]   = sram_dq_out;
      tr_dout[k] = ram.ram_dout;
      tr_dqoe[k] = sram_dq_oe;
      if (!ram.ram_ack_n) begin n_ack++; if (first_ack == 0) first_ack = k; end
      if (ram.ram_req && first_req == 0) first_req = k;
      if (!sram_oe_n) n_oe_lo++;
      if (!sram_we_n) n_we_lo++;
      if (!sram_ce_n) n_ce_lo++;
      if (sram_dq_oe) n_dqoe++;
      if (k == 2) idle_bus();
      if (rst_at > 0 && k == rst_at) i_reset = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) i_reset = 1'b0;
    end
    $display("txn %s: acks=%0d first_ack=t+%0d next_req=t+%0d ce_lo=%0d dout=0x%08h err=%0b",
             name, n_ack, first_ack, first_req, n_ce_lo, ram.ram_dout, err);
  endtask

  initial begin
    int nreq, req_first, ack_seen, strobe_seen;
    i_reset = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    chk("rst_req",   {31'd0, ram.ram_req}, 32'd0);
    chk("rst_ack_n", {31'd0, ram.ram_ack_n}, 32'd1);
    chk("rst_dout",  ram.ram_dout, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
    chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_sram_a", {14'd0, sram_a}, 32'd0);

    // Slot cadence after release: REQ in cycle 0, then every 16 cycles, one cycle wide.
    i_reset = 1'b0;
    #1;
    chk("req_cycle0", {31'd0, ram.ram_req}, 32'd1);
    nreq = 0; req_first = 0; ack_seen = 0; strobe_seen = 0;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (ram.ram_req) begin nreq++; if (req_first == 0) req_first = k; end
      if (!ram.ram_ack_n) ack_seen++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} != 5'h1F) strobe_seen++;
    end
    $display("txn idle_slots: reqs=%0d first=%0d", nreq, req_first);
    chk("req_first", req_first, 32'd16);
    chk("req_count", nreq, 32'd3);
    chk("idle_no_ack", ack_seen, 32'd0);
    chk("idle_no_strobe", strobe_seen, 32'd0);

    // 32-bit read of words 0x82/0x83.
    run_req("rd32", 1'b0, 1'b1, 1'b1, 19'h00104, 32'd0, 2'd2, 12, 0);
    chk("rd32_ack_at", first_ack, 32'd8);
    chk("rd32_ack_cnt", n_ack, 32'd1);
    chk("rd32_a_ph0", {14'd0, tr_a[2]}, 32'h82);
    chk("rd32_str_ph0", {27'd0, tr_str[2]}, 32'b00100);
    chk("rd32_str_rec0", {27'd0, tr_str[4]}, 32'h1F);
    chk("rd32_a_ph1", {14'd0, tr_a[5]}, 32'h83);
    chk("rd32_oe_lo", n_oe_lo, 32'd4);
    chk("rd32_dout", tr_dout[8], 32'hDEADBEEF);
    chk("rd32_no_dqoe", n_dqoe, 32'd0);

    // 8-bit write to the top byte of the space.
    run_req("wr8", 1'b1, 1'b0, 1'b1, 19'h7FFFF, 32'h0000005A, 2'd0, 10, 0);
    chk("wr8_ack_at", first_ack, 32'd5);
    chk("wr8_a", {14'd0, tr_a[2]}, 32'h3FFFF);
    chk("wr8_str", {27'd0, tr_str[2]}, 32'b01001);
    chk("wr8_dq", {16'd0, tr_dq[2]}, 32'h5A5A);
    chk("wr8_we_lo", n_we_lo, 32'd2);
    chk("wr8_dqoe_cycles", n_dqoe, 32'd3);
    chk("wr8_dout_kept", tr_dout[5], 32'hDEADBEEF);
    chk("wr8_mem", {16'd0, mem[18'h3FFFF]}, 32'h5A11);

    // 8-bit read of the low byte of word 0x08.
    run_req("rd8", 1'b0, 1'b1, 1'b1, 19'h00010, 32'd0, 2'd0, 10, 0);
    chk("rd8_ack_at", first_ack, 32'd5);
    chk("rd8_a", {14'd0, tr_a[2]}, 32'h08);
    chk("rd8_str", {27'd0, tr_str[2]}, 32'b00110);
    chk("rd8_dout", tr_dout[5], 32'h34343434);
    chk("rd8_err", {31'd0, err}, 32'd0);

    // Refresh, then an all-high request.
    run_req("rfsh", 1'b1, 1'b1, 1'b0, 19'd0, 32'd0, 2'd0, 20, 0);
    chk("rfsh_ack_at", first_ack, 32'd2);
    chk("rfsh_ack_cnt", n_ack, 32'd1);
    chk("rfsh_no_ce", n_ce_lo, 32'd0);
    chk("rfsh_dout_kept", tr_dout[2], 32'h34343434);
    run_req("noop", 1'b1, 1'b1, 1'b1, 19'd0, 32'd0, 2'd0, 20, 0);
    chk("noop_no_ack", n_ack, 32'd0);
    chk("noop_next_req", first_req, 32'd16);

    // Conflicting OE_n/WE_n: write still happens, ERR latches.
    run_req("wr32_err", 1'b0, 1'b0, 1'b1, 19'h00200, 32'hCAFEF00D, 2'd2, 12, 0);
    chk("err_ack_at", first_ack, 32'd8);
    chk("err_we_lo", n_we_lo, 32'd4);
    chk("err_oe_lo", n_oe_lo, 32'd0);
    chk("err_mem_lo", {16'd0, mem[18'h00100]}, 32'hF00D);
    chk("err_mem_hi", {16'd0, mem[18'h00101]}, 32'hCAFE);
    chk("err_set", {31'd0, err}, 32'd1);
    run_req("rfsh2", 1'b1, 1'b1, 1'b0, 19'd0, 32'd0, 2'd0, 4, 0);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset asserted in the first PH1 cycle of a 32-bit read.
    run_req("rd32_abort", 1'b0, 1'b1, 1'b1, 19'h00104, 32'd0, 2'd2, 30, 5);
    chk("abort_in_ph1", {27'd0, tr_str[5]}, 32'b00100);
    chk("abort_strobes", {27'd0, tr_str[6]}, 32'h1F);
    chk("abort_no_ack", n_ack, 32'd0);
    chk("abort_next_req", first_req, 32'd22);
    chk("abort_err_clr", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/t9990_vram_responder.md
Name: t9990_vram_responder

Overview:
- Memory-side responder for the tiny9990 RAM interface. Generates the RAM_REQ slot strobe and services the VDP's OE/WE/RFSH requests.
- Returns RAM_DOUT together with an RAM_ACK_n completion pulse.
- Backs the 512 KB VRAM byte space with an external 16-bit asynchronous SRAM (256K words). A 32-bit access is therefore split into two word phases.
- Sits between the T9990 top level and the board SRAM pins.

Parameters:
- SLOT_PERIOD, 16: CLK cycles between slot opportunities. Must be ≥ 2*SRAM_WAIT+6.
- SRAM_WAIT, 2: CLK cycles each SRAM strobe is held low. Valid range ≥ 1.

Ports:
- CLK  in  1  system clock; only clock.
- RESET  in  1  synchronous, active-high reset.
- RAM_REQ  out  1  one-cycle slot strobe to the VDP.
- RAM_OE_n  in  1  read request (low = read).
- RAM_WE_n  in  1  write request (low = write).
- RAM_RFSH_n  in  1  refresh request (low = refresh).
- RAM_ADDR  in  19  VRAM byte address.
- RAM_DIN  in  32  write data; 8-bit writes use [7:0].
- RAM_DIN_SIZE  in  2  0 = 8-bit, 2 = 32-bit; values 1 and 3 are treated as 32-bit and set ERR.
- RAM_DOUT  out  32  read data; valid while RAM_ACK_n is low, held afterwards.
- RAM_ACK_n  out  1  one-cycle active-low completion pulse.
- SRAM_A  out  18  SRAM word address.
- SRAM_DQ_OUT  out  16  SRAM write data.
- SRAM_DQ_IN  in  16  SRAM read data.
- SRAM_DQ_OE  out  1  high = drive DQ pins.
- SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_UB_n, SRAM_LB_n  out  1 each  SRAM strobes.
- ERR  out  1  sticky protocol-error flag.

Behaviour:
Reset values (synchronous, RESET high):
- RAM_REQ=0, RAM_ACK_n=1, RAM_DOUT=0, ERR=0.
- All SRAM strobes =1, SRAM_DQ_OE=0, SRAM_A=0, slot counter=0, FSM=IDLE.
- Reset mid-transaction aborts it: strobes return high the next cycle and no ACK is issued.

Slot counter and RAM_REQ:
- Slot counter is free-running, modulo SLOT_PERIOD.
- RAM_REQ=1 for one cycle when counter==0 and FSM==IDLE.
- If the FSM is busy at counter==0, that slot is skipped (no REQ); the counter never stalls.

SAMPLE cycle (t+1, where t is the REQ cycle):
- Capture OE_n, WE_n, RFSH_n, ADDR, DIN and SIZE.
- Decode the request; the first matching rule wins:
  - WE_n=0: write. If OE_n is also 0, set ERR and still perform the write.
  - OE_n=0: read.
  - RFSH_n=0: refresh. No SRAM activity; ACK at t+2.
  - All high: no-op. Return to IDLE at t+2 with no ACK.
- Any other RFSH_n combined with OE_n or WE_n low also sets ERR; read/write still takes precedence.

FSM states: IDLE → SAMPLE → PH0 → REC0 → PH1 → REC1 → ACK → IDLE. 8-bit accesses skip PH1/REC1.

PHn (SRAM_WAIT cycles):
- CE_n=0, plus OE_n=0 (read) or WE_n=0 (write).
- For writes, SRAM_A and DQ are stable for the whole phase and SRAM_DQ_OE=1.

RECn (1 cycle):
- All strobes high; SRAM_A and DQ held; SRAM_DQ_OE stays 1 after a write.
- In the read case, SRAM_DQ_IN is registered on the last PH cycle.

32-bit access:
- Word address base = {ADDR[18:2],1'b0}; ADDR[1:0] ignored.
- PH0 uses the base word and lanes DIN[15:0]/DOUT[15:0].
- PH1 uses base+1 and lanes [31:16] (little-endian).
- UB_n=LB_n=0 in both phases.

8-bit access:
- SRAM_A = ADDR[18:1]. ADDR[0]=0 selects LB (low byte), ADDR[0]=1 selects UB (high byte). Only the selected strobe goes low.
- Write: DQ_OUT = {DIN[7:0],DIN[7:0]}.
- Read: the selected byte is replicated into all four RAM_DOUT lanes.

ACK:
- RAM_ACK_n=0 for exactly one cycle, with RAM_DOUT updated in the same cycle.
- RAM_DOUT is updated for reads only; on writes it keeps its previous value.

Latency (W = SRAM_WAIT):
- 32-bit: ACK at t+4+2W.
- 8-bit: ACK at t+3+W.
- Refresh: ACK at t+2.

Address wrap:
- base+1 never crosses the 256K-word boundary, because base is even.

Test Plan:
1. Reset, then release (SLOT_PERIOD=16, W=2) → RAM_REQ pulses at cycles 0, 16, 32…, each 1 cycle wide; all strobes high; RAM_ACK_n=1.
2. 32-bit read, ADDR=0x00104, SRAM words 0x82=0xBEEF and 0x83=0xDEAD → SRAM_A=0x82 then 0x83; ACK at t+8; RAM_DOUT=0xDEADBEEF.
3. 8-bit write, ADDR=0x7FFFF, DIN[7:0]=0x5A → SRAM_A=0x3FFFF; UB_n=0, LB_n=1; DQ_OUT=0x5A5A; WE_n low for 2 cycles; ACK at t+5.
4. 8-bit read, ADDR=0x00010, word 0x08=0x1234 → RAM_DOUT=0x34343434; ACK at t+5.
5. Refresh only, then all-high request → first: ACK at t+2 with no SRAM strobes; second: no ACK, next REQ at t+16.
6. OE_n=WE_n=0 with SIZE=2 → write performed, ERR=1 sticky until RESET. Separately, assert RESET during PH1 → strobes high the next cycle, no ACK, RAM_REQ resumes from counter 0.
